pipe_if_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and selects the next PC from the ID-stage control-flow select. It runs a request/ready handshake to a variable-latency instruction memory. Each cycle it presents either a fetched instruction plus its PC+4, or a NOP bubble, to the IF/ID register.

---
 rtl/pipe_if_stage.sv | 136 +++++++++++++
 tb/tb_pipe_if_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency instruction memory
// and presents either a fetched instruction or a NOP bubble to the IF/ID register.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc4,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        redirect;
  logic        avail;
  logic [31:0] avail_data;
  logic        deliver;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    npc = pc_plus4;
    case (pcsource)
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      2'b11:   npc = jpc;
      default: npc = pc_plus4;
    endcase
  end

  // A redirect only counts while ID is advancing; otherwise ID re-presents it.
  assign redirect = wpcir && (pcsource != 2'b00);

  always_comb begin
    avail      = 1'b0;
    avail_data = imem_rdata;
    case (state_q)
      StWait: avail = imem_ready;
      StHold: begin
        avail      = 1'b1;
        avail_data = hold_q;
      end
      default: avail = 1'b0;
    endcase
  end

  assign deliver = avail && wpcir;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    redir_d = redir_q;
    count_d = count_q;

    if (deliver) begin
      pc_d    = npc;
      count_d = count_q + 32'd1;
    end

    case (state_q)
      StIdle: state_d = StWait;
      StWait: begin
        if (imem_ready) begin
          if (!wpcir) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end else if (redirect) begin
          // Request address must stay put, so park the target until the memory answers.
          redir_d = npc;
          state_d = StDrop;
        end
      end
      StHold: begin
        if (wpcir) begin
          state_d = StWait;
        end
      end
      StDrop: begin
        if (imem_ready) begin
          pc_d    = redirect ? npc : redir_q;
          state_d = StWait;
        end else if (redirect) begin
          redir_d = npc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      redir_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == StWait) || (state_q == StDrop);
  assign imem_addr   = pc_q;
  assign ins         = deliver ? avail_data : NOP_INSN;
  assign pc4         = pc_plus4;
  assign fetch_count = count_q;

  addr_stable_a: assert property (@(posedge clock) disable iff (!resetn)
    (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed vector table, hand-written reset/counter-wrap sequence,
// then randomized traffic against a variable-latency memory checked by a reference model.
module tb_pipe_if_stage;

  logic        clock;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins, pc4, fetch_count;

  int checks = 0;
  int errors = 0;

  pipe_if_stage dut (
    .clock      (clock),
    .resetn     (resetn),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .pc4        (pc4),
    .fetch_count(fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        wp;
    logic [1:0]  pcs;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Only the selected target carries the real value; the others are decoys.
  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic wp,
                       input logic [1:0] pcs, input logic [31:0] tgt);
    imem_ready = rdy;
    imem_rdata = rdata;
    wpcir      = wp;
    pcsource   = pcs;
    bpc        = (pcs == 2'b01) ? tgt : 32'h1111_0000;
    rpc        = (pcs == 2'b10) ? tgt : 32'h2222_0000;
    jpc        = (pcs == 2'b11) ? tgt : 32'h3333_0000;
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] i, input logic [31:0] p4,
                            input logic [31:0] cnt);
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".ins"}, ins, i);
    chk({tag, ".pc4"}, pc4, p4);
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  // Reference model state: fetch progress described as flags, not as the DUT's encoding.
  bit          m_started;
  bit          m_held;
  logic [31:0] m_hold_word;
  bit          m_drop;
  logic [31:0] m_redir;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  function automatic logic [31:0] pick_target(input logic [1:0] s, input logic [31:0] pc,
                                              input logic [31:0] b, input logic [31:0] r,
                                              input logic [31:0] j);
    case (s)
      2'b01:   return b;
      2'b10:   return r;
      2'b11:   return j;
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic model_reset();
    m_started   = 0;
    m_held      = 0;
    m_hold_word = 32'h0;
    m_drop      = 0;
    m_redir     = 32'h0;
    m_pc        = 32'h0;
    m_count     = 32'h0;
  endtask

  task automatic model_cycle(input string tag);
    bit          fetching, avail, give, take_redir;
    logic [31:0] word, tgt;
    fetching   = m_started && !m_held && !m_drop;
    avail      = m_held || (fetching && imem_ready);
    word       = m_held ? m_hold_word : imem_rdata;
    give       = avail && wpcir;
    take_redir = wpcir && (pcsource != 2'b00);
    tgt        = pick_target(pcsource, m_pc, bpc, rpc, jpc);

    check_outs(tag, m_started && !m_held, m_pc, give ? word : 32'h0, m_pc + 32'd4, m_count);

    if (!m_started) begin
      m_started = 1;
    end else if (give) begin
      m_pc    = tgt;
      m_count = m_count + 32'd1;
      m_held  = 0;
    end else if (fetching && imem_ready) begin
      m_held      = 1;
      m_hold_word = imem_rdata;
    end else if (fetching && take_redir) begin
      m_drop  = 1;
      m_redir = tgt;
    end else if (m_drop) begin
      if (imem_ready) begin
        m_drop = 0;
        m_pc   = take_redir ? tgt : m_redir;
      end else if (take_redir) begin
        m_redir = tgt;
      end
    end
  endtask

  initial begin
    bit          busy;
    int unsigned lat, cnt;
    logic [31:0] word;

    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);

    // rdy, rdata, wp, pcs, tgt | req, addr, ins, pc4, count
    tbl.push_back('{1'b1, 32'hBAD0_BAD0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 32'd0});
    tbl.push_back('{1'b1, 32'hA000_0000, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h0, 32'hA000_0000, 32'h4, 32'd0});
    tbl.push_back('{1'b1, 32'hA000_0004, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h4, 32'hA000_0004, 32'h8, 32'd1});
    tbl.push_back('{1'b1, 32'hA000_0008, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h8, 32'hA000_0008, 32'hC, 32'd2});
    tbl.push_back('{1'b1, 32'hA000_000C, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'hC, 32'hA000_000C, 32'h10, 32'd3});
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{1'b0, 32'hDEAD_0010, 1'b1, 2'd0, 32'h0,
                      1'b1, 32'h10, 32'h0, 32'h14, 32'd4});
    end
    tbl.push_back('{1'b1, 32'hDEAD_0010, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h10, 32'hDEAD_0010, 32'h14, 32'd4});
    tbl.push_back('{1'b1, 32'hB000_0014, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h14, 32'hB000_0014, 32'h18, 32'd5});
    tbl.push_back('{1'b1, 32'hB000_0018, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h18, 32'hB000_0018, 32'h1C, 32'd6});
    tbl.push_back('{1'b1, 32'hB000_001C, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h1C, 32'hB000_001C, 32'h20, 32'd7});
    tbl.push_back('{1'b1, 32'h1234_5678, 1'b0, 2'd0, 32'h0,
                    1'b1, 32'h20, 32'h0, 32'h24, 32'd8});
    tbl.push_back('{1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0,
                    1'b0, 32'h20, 32'h0, 32'h24, 32'd8});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0, 2'd1, 32'h700,
                    1'b0, 32'h20, 32'h0, 32'h24, 32'd8});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd0, 32'h0,
                    1'b0, 32'h20, 32'h1234_5678, 32'h24, 32'd8});
    tbl.push_back('{1'b1, 32'hC000_0024, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h24, 32'hC000_0024, 32'h28, 32'd9});
    tbl.push_back('{1'b1, 32'hC000_0028, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h28, 32'hC000_0028, 32'h2C, 32'd10});
    tbl.push_back('{1'b1, 32'hC000_002C, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h2C, 32'hC000_002C, 32'h30, 32'd11});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd1, 32'h100, 1'b1, 32'h30, 32'h0, 32'h34, 32'd12});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd0, 32'h0, 1'b1, 32'h30, 32'h0, 32'h34, 32'd12});
    tbl.push_back('{1'b1, 32'h9999_9999, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h30, 32'h0, 32'h34, 32'd12});
    tbl.push_back('{1'b1, 32'hC000_0100, 1'b1, 2'd3, 32'h2000,
                    1'b1, 32'h100, 32'hC000_0100, 32'h104, 32'd12});
    tbl.push_back('{1'b1, 32'h1, 1'b1, 2'd0, 32'h0, 1'b1, 32'h2000, 32'h1, 32'h2004, 32'd13});
    tbl.push_back('{1'b1, 32'h2, 1'b1, 2'd2, 32'hFFFF_FFFC,
                    1'b1, 32'h2004, 32'h2, 32'h2008, 32'd14});
    tbl.push_back('{1'b1, 32'h3, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'hFFFF_FFFC, 32'h3, 32'h0, 32'd15});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h4, 32'd16});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 2'd1, 32'h500, 1'b1, 32'h0, 32'h0, 32'h4, 32'd16});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd1, 32'h400, 1'b1, 32'h0, 32'h0, 32'h4, 32'd16});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 2'd2, 32'h800, 1'b1, 32'h0, 32'h0, 32'h4, 32'd16});
    tbl.push_back('{1'b1, 32'h7, 1'b1, 2'd0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h4, 32'd16});
    tbl.push_back('{1'b1, 32'h800, 1'b1, 2'd0, 32'h0,
                    1'b1, 32'h800, 32'h800, 32'h804, 32'd16});

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check_outs("reset", 1'b0, 32'h0, 32'h0, 32'h4, 32'h0);

    // Directed table, first row is the IDLE cycle right after release
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clock);
      drive(tbl[i].rdy, tbl[i].rdata, tbl[i].wp, tbl[i].pcs, tbl[i].tgt);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ins, tbl[i].pc4,
                 tbl[i].cnt);
    end

    // Reset while a request is outstanding
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
    #1;
    chk("midreq.req_before", {31'h0, imem_req}, 32'h1);
    resetn = 1'b0;
    #1;
    check_outs("midreq", 1'b0, 32'h0, 32'h0, 32'h4, 32'h0);
    chk("midreq.addr", imem_addr, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check_outs("midreq.idle", 1'b0, 32'h0, 32'h0, 32'h4, 32'h0);

    // Counter wrap: preset the count just below the wrap point
    @(negedge clock);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    drive(1'b1, 32'h0000_0055, 1'b1, 2'b00, 32'h0);
    #1;
    check_outs("wrap.pre", 1'b1, 32'h0, 32'h55, 32'h4, 32'hFFFF_FFFF);
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
    #1;
    check_outs("wrap.post", 1'b1, 32'h4, 32'h0, 32'h8, 32'h0);

    // Randomized traffic
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    busy = 0;
    lat  = 0;
    cnt  = 0;
    word = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clock);
      if (!imem_req) begin
        busy = 0;
      end else if (!busy) begin
        busy = 1;
        cnt  = 0;
        lat  = $urandom_range(0, 3);
        word = $urandom;
      end
      imem_ready = imem_req ? (busy && cnt == lat) : 1'($urandom_range(0, 1));
      imem_rdata = imem_req ? word : $urandom;
      wpcir      = ($urandom_range(0, 3) != 0);
      pcsource   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bpc        = $urandom;
      rpc        = $urandom;
      jpc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      #1;
      model_cycle($sformatf("rnd%0d", c));
      if (imem_req && imem_ready) busy = 0;
      else if (imem_req) cnt++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
